// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the CPU front end: RV opcode constants, the canonical
//   NOP word (addi x0,x0,0), and the fetch engine state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_SD    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_skid_buffer.sv
// -----------------------------------------------------------------------------
// if_skid_buffer
//   One-entry store for an instruction word (and its PC) that came back from
//   memory while decode was stalled.
// Ports
//   clk       in   1     clock
//   rst_n     in   1     synchronous reset, active-low (empties the entry)
//   load      in   1     capture instr_in/pc_in, mark entry valid
//   clear     in   1     empty the entry (wins over load)
//   instr_in  in   32    word to capture
//   pc_in     in   XLEN  PC of the word to capture
//   valid     out  1     entry holds a word
//   instr     out  32    stored word
//   pc        out  XLEN  stored PC
// -----------------------------------------------------------------------------
module if_skid_buffer
   import cpu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);

   logic            valid_reg;
   logic [31:0]     instr_reg;
   logic [XLEN-1:0] pc_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         instr_reg <= INSTR_NOP;
         pc_reg    <= '0;
      end else if (clear) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
         instr_reg <= instr_in;
         pc_reg    <= pc_in;
      end
   end

   assign valid = valid_reg;
   assign instr = instr_reg;
   assign pc    = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   IF stage: issues one instruction-memory request at a time in PC order,
//   places returned words in the IF/ID register, parks a word in a skid buffer
//   while decode stalls, and flushes/redirects on taken control flow.
// Ports
//   clk              in   1     clock
//   rst_n            in   1     synchronous reset, active-low
//   hazard_detected  in   1     stall: freeze IF/ID and PC
//   redirect         in   1     taken branch / jal / jalr this cycle
//   redirect_pc      in   XLEN  target PC (low two bits ignored)
//   imem_req         out  1     one-cycle request pulse
//   imem_addr        out  XLEN  request address (current PC)
//   imem_rvalid      in   1     response valid
//   imem_rdata       in   32    response word
//   ifid_valid       out  1     IF/ID holds a live instruction
//   ifid_pc          out  XLEN  PC of ifid_instr
//   ifid_instr       out  32    instruction, NOP when invalid
//   op_code          out  7     ifid_instr[6:0] for the control decoder
// -----------------------------------------------------------------------------
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hazard_detected,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            ifid_valid,
   output logic [XLEN-1:0] ifid_pc,
   output logic [31:0]     ifid_instr,
   output logic [6:0]      op_code
);

   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic            discard_reg, discard_next;

   logic            ifid_valid_reg, ifid_valid_next;
   logic [XLEN-1:0] ifid_pc_reg, ifid_pc_next;
   logic [31:0]     ifid_instr_reg, ifid_instr_next;

   logic            skid_valid;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_pc;

   logic            word_live;     // response that belongs to the current PC
   logic            take_word;     // response goes straight into IF/ID
   logic            park_word;     // response goes into the skid buffer
   logic            release_skid;  // skid entry moves into IF/ID
   logic            advance;       // an instruction was delivered, step PC

   // A response is only meaningful in WAIT; a pending or same-cycle redirect
   // makes it stale.
   assign word_live    = (state_reg == WAIT) && imem_rvalid && !discard_reg && !redirect;
   assign take_word    = word_live && !hazard_detected;
   assign park_word    = word_live && hazard_detected;
   assign release_skid = (state_reg == HOLD) && skid_valid && !hazard_detected && !redirect;
   assign advance      = take_word || release_skid;

   if_skid_buffer #(.XLEN(XLEN)) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (park_word),
      .clear    (redirect || release_skid),
      .instr_in (imem_rdata),
      .pc_in    (pc_reg),
      .valid    (skid_valid),
      .instr    (skid_instr),
      .pc       (skid_pc)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  state_next = FETCH;
         FETCH: state_next = WAIT;   // the request issues even on redirect
         WAIT: begin
            if (imem_rvalid) begin
               if (redirect || discard_reg || !hazard_detected) begin
                  state_next = FETCH;
               end else begin
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect || !hazard_detected) begin
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      imem_req  = (state_reg == FETCH);
      imem_addr = pc_reg;
   end

   // Discard marks the outstanding request as stale after a redirect, so the
   // word it eventually returns is dropped instead of entering IF/ID.
   always_comb begin
      discard_next = discard_reg;
      case (state_reg)
         FETCH: begin
            if (redirect) begin
               discard_next = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               discard_next = 1'b0;
            end else if (redirect) begin
               discard_next = 1'b1;
            end
         end
         default: discard_next = discard_reg;
      endcase
   end

   always_comb begin
      pc_next = pc_reg;
      if (redirect) begin
         pc_next = redirect_pc & ALIGN_MASK;
      end else if (advance) begin
         pc_next = pc_reg + PC_STEP;   // wraps modulo 2^XLEN
      end
   end

   // IF/ID priority: redirect flush > stall freeze > new word > bubble.
   always_comb begin
      ifid_valid_next = ifid_valid_reg;
      ifid_pc_next    = ifid_pc_reg;
      ifid_instr_next = ifid_instr_reg;
      if (redirect) begin
         ifid_valid_next = 1'b0;
         ifid_instr_next = INSTR_NOP;
      end else if (!hazard_detected) begin
         if (take_word) begin
            ifid_valid_next = 1'b1;
            ifid_pc_next    = pc_reg;
            ifid_instr_next = imem_rdata;
         end else if (release_skid) begin
            ifid_valid_next = 1'b1;
            ifid_pc_next    = skid_pc;
            ifid_instr_next = skid_instr;
         end else begin
            ifid_valid_next = 1'b0;
            ifid_instr_next = INSTR_NOP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_reg         <= RESET_PC;
         discard_reg    <= 1'b0;
         ifid_valid_reg <= 1'b0;
         ifid_pc_reg    <= '0;
         ifid_instr_reg <= INSTR_NOP;
      end else begin
         pc_reg         <= pc_next;
         discard_reg    <= discard_next;
         ifid_valid_reg <= ifid_valid_next;
         ifid_pc_reg    <= ifid_pc_next;
         ifid_instr_reg <= ifid_instr_next;
      end
   end

   assign ifid_valid = ifid_valid_reg;
   assign ifid_pc    = ifid_pc_reg;
   assign ifid_instr = ifid_instr_reg;
   assign op_code    = ifid_instr_reg[6:0];

endmodule
